// File: rtl/load_ext_pipe_pkg.sv
// Shared CPU load definitions: load-type encodings, access sizes and
// small decode helpers used by the load pipeline and the instruction decoder.
package load_ext_pipe_pkg;

   // 3-bit load-type encodings
   typedef enum logic [2:0] {
      LD_LB   = 3'b000,
      LD_LBU  = 3'b001,
      LD_LH   = 3'b010,
      LD_LHU  = 3'b011,
      LD_LW   = 3'b100,
      LD_LWU  = 3'b101,
      LD_LD   = 3'b110,
      LD_RSVD = 3'b111
   } load_type_e;

   // Access sizes in bytes; SIZE_NONE marks the reserved encoding
   localparam logic [3:0] SIZE_NONE = 4'd0;
   localparam logic [3:0] SIZE_B    = 4'd1;
   localparam logic [3:0] SIZE_H    = 4'd2;
   localparam logic [3:0] SIZE_W    = 4'd4;
   localparam logic [3:0] SIZE_D    = 4'd8;

   // Number of bytes touched by a load type
   function automatic logic [3:0] load_size(input logic [2:0] ltype);
      logic [3:0] size;
      case (ltype)
         LD_LB, LD_LBU: size = SIZE_B;
         LD_LH, LD_LHU: size = SIZE_H;
         LD_LW, LD_LWU: size = SIZE_W;
         LD_LD:         size = SIZE_D;
         LD_RSVD:       size = SIZE_NONE;
         default:       size = SIZE_NONE;
      endcase
      return size;
   endfunction

   // Loads that sign-extend their result
   function automatic logic load_is_signed(input logic [2:0] ltype);
      return (ltype == LD_LB) || (ltype == LD_LH) || (ltype == LD_LW);
   endfunction

endpackage

// File: rtl/load_lane_sel.sv
// Combinational byte-lane selection: picks the addressed bytes out of the raw
// memory word, right-aligns them to bit 0 and flags misaligned/illegal loads.
module load_lane_sel
   import load_ext_pipe_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter bit BIG_ENDIAN = 1'b0,
   localparam int NB        = DATA_W / 8,
   localparam int AW        = $clog2(NB)
) (
   input  logic [DATA_W-1:0] data,
   input  logic [AW-1:0]     addr_lo,
   input  logic [2:0]        ltype,
   output logic [DATA_W-1:0] aligned,
   output logic [DATA_W-1:0] mask,
   output logic              err
);

   logic [3:0]        size;
   logic [3:0]        addr4;
   logic [3:0]        lane_off;
   logic [DATA_W-1:0] shifted;

   assign size  = load_size(ltype);
   assign addr4 = 4'(addr_lo);

   // Byte-granular mask covering the low 'size' bytes of the result
   for (genvar gi = 0; gi < NB; gi++) begin : g_mask
      assign mask[8*gi +: 8] = (4'(gi) < size) ? 8'hFF : 8'h00;
   end

   // Big-endian puts the lowest address in the most significant lane, so
   // the aligned field sits at the mirrored lane offset within the word.
   assign lane_off = BIG_ENDIAN ? (4'(NB) - addr4 - size) : addr4;
   assign shifted  = data >> {lane_off, 3'b000};

   // Legality: reserved type, access wider than the bus, LWU on a 32-bit
   // bus, or an offset that is not a multiple of the access size
   always_comb begin
      err = 1'b0;
      if (size == SIZE_NONE) begin
         err = 1'b1;
      end else if (size > 4'(NB)) begin
         err = 1'b1;
      end else if ((DATA_W == 32) && (ltype == LD_LWU)) begin
         err = 1'b1;
      end else if ((addr4 & (size - 4'd1)) != 4'd0) begin
         err = 1'b1;
      end
   end

   assign aligned = err ? '0 : (shifted & mask);

endmodule

// File: rtl/load_ext_pipe.sv
// Two-stage load extension pipeline: S1 selects and aligns the addressed
// bytes, S2 sign/zero-extends and holds the result under back-pressure.
module load_ext_pipe
   import load_ext_pipe_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int TAG_W      = 5,
   parameter bit BIG_ENDIAN = 1'b0,
   localparam int AW        = $clog2(DATA_W / 8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [AW-1:0]     in_addr_lo,
   input  logic [2:0]        in_type,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err,
   output logic [15:0]       err_count
);

   logic [DATA_W-1:0] sel_aligned;
   logic [DATA_W-1:0] sel_mask;
   logic              sel_err;

   logic              s1_valid_reg;
   logic [DATA_W-1:0] s1_data_reg;
   logic [DATA_W-1:0] s1_mask_reg;
   logic [3:0]        s1_size_reg;
   logic              s1_signed_reg;
   logic              s1_err_reg;
   logic [TAG_W-1:0]  s1_tag_reg;

   logic              out_valid_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic [TAG_W-1:0]  out_tag_reg;
   logic              out_err_reg;
   logic [15:0]       err_count_reg;

   logic              s2_can;
   logic              sign_bit;
   logic [DATA_W-1:0] ext_data_next;

   load_lane_sel #(
      .DATA_W     (DATA_W),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_lane_sel (
      .data    (in_data),
      .addr_lo (in_addr_lo),
      .ltype   (in_type),
      .aligned (sel_aligned),
      .mask    (sel_mask),
      .err     (sel_err)
   );

   // S2 can take new data when empty or when its content leaves this cycle
   assign s2_can   = !out_valid_reg || out_ready;
   assign in_ready = !s1_valid_reg || s2_can;

   // Stage 1: capture the aligned field plus what S2 needs to extend it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s1_data_reg   <= '0;
         s1_mask_reg   <= '0;
         s1_size_reg   <= SIZE_NONE;
         s1_signed_reg <= 1'b0;
         s1_err_reg    <= 1'b0;
         s1_tag_reg    <= '0;
      end else if (flush) begin
         s1_valid_reg <= 1'b0;
      end else if (in_ready) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_data_reg   <= sel_aligned;
            s1_mask_reg   <= sel_mask;
            s1_size_reg   <= load_size(in_type);
            s1_signed_reg <= load_is_signed(in_type);
            s1_err_reg    <= sel_err;
            s1_tag_reg    <= in_tag;
         end
      end
   end

   // Extension: replicate the field's top bit above the mask for signed loads
   always_comb begin
      sign_bit = 1'b0;
      case (s1_size_reg)
         SIZE_B:  sign_bit = s1_data_reg[7];
         SIZE_H:  sign_bit = s1_data_reg[15];
         SIZE_W:  sign_bit = s1_data_reg[31];
         default: sign_bit = 1'b0;
      endcase
      ext_data_next = s1_data_reg |
                      ({DATA_W{s1_signed_reg & sign_bit}} & ~s1_mask_reg);
   end

   // Stage 2: output register, frozen while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_tag_reg   <= '0;
         out_err_reg   <= 1'b0;
      end else if (flush) begin
         out_valid_reg <= 1'b0;
      end else if (s2_can) begin
         out_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            out_data_reg <= ext_data_next;
            out_tag_reg  <= s1_tag_reg;
            out_err_reg  <= s1_err_reg;
         end
      end
   end

   // Saturating count of errored transfers; a flush does not cancel the
   // transfer completing in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count_reg <= 16'h0000;
      end else if (out_valid_reg && out_ready && out_err_reg &&
                   (err_count_reg != 16'hFFFF)) begin
         err_count_reg <= err_count_reg + 16'd1;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_tag   = out_tag_reg;
   assign out_err   = out_err_reg;
   assign err_count = err_count_reg;

endmodule

// File: tb/tb_load_ext_pipe.sv
// Bench for load_ext_pipe: three instances (32-bit LE, 32-bit BE, 64-bit LE)
// share one stimulus stream and are each checked against a byte-level model.
module tb_load_ext_pipe;

   typedef struct {
      logic [63:0] data;
      logic        err;
      logic [4:0]  tag;
   } exp_t;

   typedef struct {
      int          inst;
      logic [2:0]  typ;
      logic [2:0]  addr;
      logic [63:0] data;
      logic [63:0] exp;
      logic        experr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [2:0]  in_type = 3'd0;
   logic [2:0]  in_addr = 3'd0;
   logic [63:0] in_data = 64'd0;
   logic [4:0]  in_tag = 5'd0;

   logic        rdy [3];
   logic        ov  [3];
   logic        oe  [3];
   logic [4:0]  ot  [3];
   logic [15:0] ec  [3];
   logic [63:0] od  [3];
   logic [31:0] d0, d1;
   logic [63:0] d2;

   int   n_cmp = 0;
   int   n_fail = 0;
   exp_t q [3][$];
   int   exp_ec [3];
   bit   stalled [3];
   exp_t saved [3];
   vec_t vecs [16];
   int   vk;
   bit   bp_drop;

   assign od[0] = {32'h0, d0};
   assign od[1] = {32'h0, d1};
   assign od[2] = d2;

   always #5 clk = ~clk;

   load_ext_pipe #(.DATA_W(32), .TAG_W(5), .BIG_ENDIAN(1'b0)) dut_le32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_data(in_data[31:0]), .in_addr_lo(in_addr[1:0]), .in_type(in_type), .in_tag(in_tag),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(d0), .out_tag(ot[0]),
      .out_err(oe[0]), .err_count(ec[0]));

   load_ext_pipe #(.DATA_W(32), .TAG_W(5), .BIG_ENDIAN(1'b1)) dut_be32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_data(in_data[31:0]), .in_addr_lo(in_addr[1:0]), .in_type(in_type), .in_tag(in_tag),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(d1), .out_tag(ot[1]),
      .out_err(oe[1]), .err_count(ec[1]));

   load_ext_pipe #(.DATA_W(64), .TAG_W(5), .BIG_ENDIAN(1'b0)) dut_le64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_data(in_data), .in_addr_lo(in_addr), .in_type(in_type), .in_tag(in_tag),
      .out_valid(ov[2]), .out_ready(out_ready), .out_data(d2), .out_tag(ot[2]),
      .out_err(oe[2]), .err_count(ec[2]));

   task automatic check(input string name, input int k, input logic [63:0] act,
                        input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s inst%0d: got %h expected %h", name, k, act, want);
      end
   endtask

   // Memory viewed as an array of bytes; a load gathers n consecutive bytes
   // in address order and combines them according to endianness.
   function automatic exp_t model(input int k, input logic [2:0] t, input logic [2:0] a3,
                                  input logic [63:0] d, input logic [4:0] g);
      int          dw;
      bit          be;
      int          nb;
      int          addr;
      int          n;
      bit          sgn;
      logic [7:0]  mem [8];
      logic [63:0] v;
      exp_t        r;
      dw   = (k == 2) ? 64 : 32;
      be   = (k == 1);
      nb   = dw / 8;
      addr = int'(a3) % nb;
      n    = 0;
      sgn  = 1'b0;
      case (t)
         3'd0: begin n = 1; sgn = 1'b1; end
         3'd1: n = 1;
         3'd2: begin n = 2; sgn = 1'b1; end
         3'd3: n = 2;
         3'd4: begin n = 4; sgn = 1'b1; end
         3'd5: n = 4;
         3'd6: n = 8;
         default: n = 0;
      endcase
      r.tag  = g;
      r.err  = (n == 0) || (n > nb) || (dw == 32 && t == 3'd5) || ((addr % n) != 0);
      r.data = 64'd0;
      if (!r.err) begin
         for (int i = 0; i < nb; i++)
            mem[i] = be ? d[dw-1-8*i -: 8] : d[8*i +: 8];
         v = 64'd0;
         for (int j = 0; j < n; j++) begin
            if (be) v = (v << 8) | 64'(mem[addr+j]);
            else    v = v | (64'(mem[addr+j]) << (8*j));
         end
         if (sgn && v[8*n-1]) v = v | (~64'h0 << (8*n));
         if (dw == 32) v[63:32] = 32'h0;
         r.data = v;
      end
      return r;
   endfunction

   // Scoreboard: ordered expectation queues, hold-stability and err_count
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int k = 0; k < 3; k++) begin
               q[k].delete();
               exp_ec[k]  = 0;
               stalled[k] = 1'b0;
            end
         end else begin
            for (int k = 0; k < 3; k++) begin
               if (stalled[k] && ov[k]) begin
                  check("hold_data", k, od[k], saved[k].data);
                  check("hold_tag", k, 64'(ot[k]), 64'(saved[k].tag));
                  check("hold_err", k, 64'(oe[k]), 64'(saved[k].err));
               end
               stalled[k]    = ov[k] && !out_ready;
               saved[k].data = od[k];
               saved[k].err  = oe[k];
               saved[k].tag  = ot[k];
               check("err_count", k, 64'(ec[k]), 64'(exp_ec[k]));
               if (ov[k] && out_ready) begin
                  if (q[k].size() == 0) begin
                     n_cmp++;
                     n_fail++;
                     $display("FAIL spurious_out inst%0d: got tag %0d, expected no output", k, ot[k]);
                  end else begin
                     e = q[k].pop_front();
                     check("out_data", k, od[k], e.data);
                     check("out_err", k, 64'(oe[k]), 64'(e.err));
                     check("out_tag", k, 64'(ot[k]), 64'(e.tag));
                     if (e.err && exp_ec[k] < 65535) exp_ec[k]++;
                  end
               end
               if (flush) q[k].delete();
               else if (in_valid && rdy[k])
                  q[k].push_back(model(k, in_type, in_addr, in_data, in_tag));
            end
         end
      end
   end

   task automatic send(input logic [2:0] t, input logic [2:0] a, input logic [63:0] d,
                       input logic [4:0] g);
      int w;
      w        = 0;
      in_valid = 1'b1;
      in_type  = t;
      in_addr  = a;
      in_data  = d;
      in_tag   = g;
      @(negedge clk);
      while (!rdy[0] && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!rdy[0]) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout inst0: got in_ready 0 for %0d cycles, expected 1", w);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic check_drained();
      for (int k = 0; k < 3; k++)
         check("queue_drained", k, 64'(q[k].size()), 64'd0);
   endtask

   initial begin
      vecs[0]  = '{0, 3'd0, 3'd1, 64'h1234_80FF, 64'hFFFF_FF80, 1'b0};
      vecs[1]  = '{0, 3'd3, 3'd2, 64'h8001_0000, 64'h0000_8001, 1'b0};
      vecs[2]  = '{0, 3'd2, 3'd2, 64'h8001_0000, 64'hFFFF_8001, 1'b0};
      vecs[3]  = '{1, 3'd2, 3'd0, 64'h8001_0000, 64'hFFFF_8001, 1'b0};
      vecs[4]  = '{0, 3'd4, 3'd2, 64'h1234_5678, 64'h0, 1'b1};
      vecs[5]  = '{2, 3'd5, 3'd4, 64'hDEAD_BEEF_8000_0001, 64'h0000_0000_DEAD_BEEF, 1'b0};
      vecs[6]  = '{2, 3'd6, 3'd0, 64'hDEAD_BEEF_8000_0001, 64'hDEAD_BEEF_8000_0001, 1'b0};
      vecs[7]  = '{2, 3'd4, 3'd4, 64'hDEAD_BEEF_8000_0001, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0};
      vecs[8]  = '{0, 3'd5, 3'd0, 64'h8000_0000, 64'h0, 1'b1};
      vecs[9]  = '{0, 3'd6, 3'd0, 64'h1, 64'h0, 1'b1};
      vecs[10] = '{0, 3'd7, 3'd0, 64'h5, 64'h0, 1'b1};
      vecs[11] = '{0, 3'd4, 3'd0, 64'h8000_0001, 64'h0000_0000_8000_0001, 1'b0};
      vecs[12] = '{1, 3'd1, 3'd0, 64'hAB00_0000, 64'hAB, 1'b0};
      vecs[13] = '{2, 3'd2, 3'd6, 64'h8123_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8123, 1'b0};
      vecs[14] = '{2, 3'd6, 3'd4, 64'h1111_2222_3333_4444, 64'h0, 1'b1};
      vecs[15] = '{0, 3'd0, 3'd3, 64'h7F00_0000, 64'h7F, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("rst_in_ready", k, 64'(rdy[k]), 64'd1);
         check("rst_out_valid", k, 64'(ov[k]), 64'd0);
         check("rst_out_data", k, od[k], 64'd0);
         check("rst_err_count", k, 64'(ec[k]), 64'd0);
      end

      // Directed vectors with exact two-cycle latency
      for (int r = 0; r < 16; r++) begin
         vk = vecs[r].inst;
         send(vecs[r].typ, vecs[r].addr, vecs[r].data, 5'(r));
         check("lat_cycle1_valid", vk, 64'(ov[vk]), 64'd0);
         @(posedge clk);
         #1;
         check("lat_cycle2_valid", vk, 64'(ov[vk]), 64'd1);
         check("vec_data", vk, od[vk], vecs[r].exp);
         check("vec_err", vk, 64'(oe[vk]), 64'(vecs[r].experr));
         check("vec_tag", vk, 64'(ot[vk]), 64'(r));
         @(posedge clk);
         #1;
         if (r == 4) check("err_count_first", 0, 64'(ec[0]), 64'd1);
      end

      // Four back-to-back requests with the consumer stalled for three cycles
      bp_drop   = 1'b0;
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 4; i++)
               send(3'd0, 3'(i), 64'h8844_2211_F0E0_D0C0, 5'(20 + i));
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            repeat (12) begin
               @(negedge clk);
               if (in_valid && !rdy[0]) bp_drop = 1'b1;
            end
         end
      join
      repeat (6) @(posedge clk);
      #1;
      check("bp_in_ready_dropped", 0, 64'(bp_drop), 64'd1);
      check_drained();

      // Flush with both stages full and a third request presented
      out_ready = 1'b0;
      send(3'd2, 3'd0, 64'h0000_7FFF, 5'd1);
      send(3'd2, 3'd2, 64'h8000_0000, 5'd2);
      in_valid = 1'b1;
      in_type  = 3'd1;
      in_addr  = 3'd0;
      in_tag   = 5'd3;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 3; k++)
            check("flush_no_output", k, 64'(ov[k]), 64'd0);
         @(posedge clk);
         #1;
      end

      // Randomized traffic with stalls and occasional flushes
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom % 4) != 0;
         in_type   = 3'($urandom % 8);
         in_addr   = 3'($urandom % 8);
         in_data   = {$urandom, $urandom};
         in_tag    = 5'($urandom % 32);
         out_ready = ($urandom % 4) != 0;
         flush     = ($urandom % 24) == 0;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_drained();

      // Error counter saturation
      in_valid = 1'b1;
      in_type  = 3'd7;
      in_addr  = 3'd0;
      in_tag   = 5'd9;
      repeat (65540) @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
         check("err_count_saturated", k, 64'(ec[k]), 64'hFFFF);

      // Asynchronous reset in the middle of traffic
      in_valid = 1'b1;
      in_type  = 3'd0;
      in_addr  = 3'd0;
      in_data  = 64'hFF;
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("async_rst_valid", k, 64'(ov[k]), 64'd0);
         check("async_rst_data", k, od[k], 64'd0);
         check("async_rst_tag", k, 64'(ot[k]), 64'd0);
         check("async_rst_err_count", k, 64'(ec[k]), 64'd0);
      end
      in_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++)
         check("post_rst_in_ready", k, 64'(rdy[k]), 64'd1);
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/load_ext_pipe.md
LOAD_EXT_PIPE -- requirements
Module: load_ext_pipe

Interface
REQ-001 Parameter DATA_W, default 32, SHALL be the load datapath width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 5, SHALL be the width of the destination-register tag carried alongside data.
REQ-003 Parameter BIG_ENDIAN, default 0, SHALL be 1 for big-endian byte-lane selection, 0 for little-endian.
REQ-004 One clock; reset is asynchronous and active-high: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-005 flush  input  1  synchronous pipeline kill.
REQ-006 in_valid  input  1  request valid; in_ready  output  1  request accepted when both high.
REQ-007 in_data  input  DATA_W  raw memory word.
REQ-008 in_addr_lo  input  log2(DATA_W/8)  byte offset within the word.
REQ-009 in_type  input  3  load type: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 LWU, 110 LD, 111 reserved.
REQ-010 in_tag  input  TAG_W  destination tag.
REQ-011 out_valid  output  1; out_ready  input  1; transfer when both high.
REQ-012 out_data  output  DATA_W  extended result; out_tag  output  TAG_W; out_err  output  1  misaligned/illegal flag.
REQ-013 err_count  output  16  saturating count of transfers with out_err=1.

Function
REQ-014 Two register stages: S1 captures input and selects/aligns the addressed bytes to bit 0; S2 applies sign/zero extension and drives outputs.
REQ-015 Latency SHALL be exactly 2 cycles from input handshake to out_valid with no back-pressure; throughput one request per cycle.
REQ-016 Each stage SHALL advance when the stage downstream is empty or advancing; in_ready = !S1_valid || S1 advancing (combinational from out_ready allowed).
REQ-017 While out_valid=1 and out_ready=0, out_data, out_tag, out_err SHALL hold stable.
REQ-018 LB/LH/LW SHALL sign-extend from bit 7/15/31; LBU/LHU/LWU SHALL zero-extend; LD SHALL pass the full word.
REQ-019 Byte lane k (little-endian) SHALL be in_data[8k+7:8k]; with BIG_ENDIAN=1, lane k SHALL be in_data[DATA_W-1-8k -: 8].
REQ-020 in_addr_lo not a multiple of the access size (2 for H, 4 for W, 8 for D) SHALL give out_err=1, out_data=0.
REQ-021 Type 111, and LWU/LD when DATA_W=32, SHALL give out_err=1, out_data=0.
REQ-022 Tag SHALL pass through unmodified, including for errored transfers.
REQ-023 flush=1 SHALL clear both stage valids at the next edge; an input presented in the same cycle is dropped; out_valid=0 the following cycle.
REQ-024 err_count SHALL increment by 1 on each output handshake with out_err=1 and saturate at 16'hFFFF.
REQ-025 Simultaneous flush and output handshake: the transfer completes this cycle (counted), then stages clear.

Reset
REQ-026 rst=1 SHALL immediately clear S1/S2 valid, out_valid, out_err, out_data, out_tag and err_count to 0 regardless of clk.
REQ-027 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Structure
REQ-028 Load-type encodings (3-bit codes) and access-size constants SHALL live in the shared CPU package, also used by the decoder.
REQ-029 One sub-module, load_lane_sel (combinational byte/half/word selection and alignment check), SHALL be instantiated in S1.

Verification
REQ-030 DATA_W=32, LB, in_data=32'h1234_80FF, addr_lo=1 -> out_data=32'hFFFF_FF80, out_err=0, two cycles later.
REQ-031 LHU, in_data=32'h8001_0000, addr_lo=2 -> 32'h0000_8001; same with LH -> 32'hFFFF_8001; BIG_ENDIAN=1 LH addr_lo=0 -> 32'hFFFF_8001.
REQ-032 LW addr_lo=2 -> out_err=1, out_data=0, err_count=1; 65536 errored transfers -> err_count=16'hFFFF.
REQ-033 Back-to-back 4 requests, out_ready low cycles 3-5 -> in_ready drops when both stages full, outputs stable, all 4 delivered in order, no loss or duplication.
REQ-034 flush with both stages full and a new in_valid -> out_valid=0 next cycle, none of the 3 requests delivered; rst asserted mid-stream -> outputs 0 asynchronously.
REQ-035 DATA_W=64, LWU, in_data=64'hDEAD_BEEF_8000_0001, addr_lo=4 -> 64'h0000_0000_DEAD_BEEF; LD addr_lo=0 -> full word.
